// File: rtl/axis_dest_splitter.sv
// axis_dest_splitter: 1:S_COUNT AXI-Stream packet distributor keyed on a head-beat dest field (broadcast option: AXIS_SPLIT_BROADCAST_EN)
module axis_dest_splitter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_LSB   = 60,
    parameter int DEST_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [S_COUNT-1:0]            m_axis_tvalid,
    output logic [S_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [S_COUNT-1:0]            m_axis_tlast,
    input  logic [S_COUNT-1:0]            m_axis_tready,
    output logic [15:0]                   drop_cnt
);
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
    state_t                state;
    logic [S_COUNT-1:0]    sel_q;
    logic [DEST_WIDTH-1:0] dest;
    logic [S_COUNT-1:0]    slot_free;
    logic [S_COUNT-1:0]    head_mask;
    logic [S_COUNT-1:0]    route;
    logic [S_COUNT-1:0]    load;
    logic                  accept;

    assign dest      = s_axis_tdata[DEST_LSB +: DEST_WIDTH];
    assign slot_free = ~m_axis_tvalid | m_axis_tready;

    // decode the head beat's dest into a port mask; empty mask means the packet is dropped
    always_comb begin
        head_mask = '0;
        for (int i = 0; i < S_COUNT; i++) head_mask[i] = (32'(dest) == i);
`ifdef AXIS_SPLIT_BROADCAST_EN
        if (dest == {DEST_WIDTH{1'b1}}) head_mask = '1;
`endif
    end

    // the input may advance only when every slot the beat targets can take it
    always_comb begin
        route         = state == IDLE ? head_mask : state == FWD ? sel_q : '0;
        s_axis_tready = rst_n && &(slot_free | ~route);
        accept        = s_axis_tvalid && s_axis_tready;
        load          = accept ? route : '0;
    end

    // packet tracking: latch the target on the head beat, count drained packets on their tlast
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (state == IDLE && |head_mask) sel_q <= head_mask;
            state <= s_axis_tlast ? IDLE : state == IDLE ? (|head_mask ? FWD : DROP) : state;
            if (s_axis_tlast && route == '0 && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // per-port output registers: load a routed beat, otherwise release on the downstream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= '0;
            m_axis_tlast  <= '0;
            m_axis_tdata  <= '0;
        end else begin
            for (int i = 0; i < S_COUNT; i++) begin
                if (load[i]) begin
                    m_axis_tvalid[i]                         <= 1'b1;
                    m_axis_tlast[i]                          <= s_axis_tlast;
                    m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata;
                end else if (m_axis_tready[i]) begin
                    m_axis_tvalid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_dest_splitter.sv
// tb_axis_dest_splitter: vector table, directed corner sequences and random packets against a per-port queue model
module tb_axis_dest_splitter;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_tvalid = 1'b0;
    logic [63:0]    s_tdata = '0;
    logic           s_tlast = 1'b0;
    logic           s_tready;
    logic [S-1:0]   m_tvalid;
    logic [S*64-1:0] m_tdata;
    logic [S-1:0]   m_tlast;
    logic [S-1:0]   m_tready = '1;
    logic [15:0]    drop_cnt;

    always #5 clk = ~clk;

    axis_dest_splitter #(.S_COUNT(S), .DATA_WIDTH(64), .DEST_LSB(60), .DEST_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .drop_cnt(drop_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;
    typedef logic [64:0] beat_q_t[$];
    beat_q_t q[S];
    int drops = 0;
    int cur = 0;
    bit mid = 1'b0;
    bit acc = 1'b0;

    typedef struct {
        logic [3:0]   dest;
        logic [S-1:0] mr;
        logic [S-1:0] exp_mv;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h want %h", name, act, exp);
    endtask

    // model step just before the rising edge: score delivered beats, then enqueue the accepted input beat
    task automatic sample();
        logic [64:0] exp;
        logic [64:0] got;
        #2;
        for (int i = 0; i < S; i++) begin
            if (m_tvalid[i] && m_tready[i]) begin
                n_chk++;
                got = {m_tlast[i], m_tdata[i*64 +: 64]};
                if (q[i].size() == 0) begin
                    $display("FAIL unexpected beat port%0d got %h", i, got);
                end else begin
                    exp = q[i].pop_front();
                    if (got === exp) n_pass++;
                    else $display("FAIL beat port%0d got %h want %h", i, got, exp);
                end
            end
        end
        acc = s_tvalid && s_tready;
        if (acc) begin
            if (!mid) cur = int'(s_tdata[63:60]);
            if (cur < S) q[cur].push_back({s_tlast, s_tdata});
`ifdef AXIS_SPLIT_BROADCAST_EN
            else if (cur == 15) for (int i = 0; i < S; i++) q[i].push_back({s_tlast, s_tdata});
`endif
            else if (s_tlast && drops < 65535) drops++;
            mid = !s_tlast;
        end
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int len;
        int guard;
        logic [3:0] dsel [7];
        logic [3:0] d;
        dsel = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd15};

        tbl[0] = '{4'd2,  4'b1111, 4'b0100};
        tbl[1] = '{4'd0,  4'b1111, 4'b0001};
        tbl[2] = '{4'd3,  4'b1111, 4'b1000};
        tbl[3] = '{4'd1,  4'b1111, 4'b0010};
        tbl[4] = '{4'd5,  4'b1111, 4'b0000};
`ifdef AXIS_SPLIT_BROADCAST_EN
        tbl[5] = '{4'd15, 4'b1111, 4'b1111};
`else
        tbl[5] = '{4'd15, 4'b1111, 4'b0000};
`endif
        tbl[6] = '{4'd2,  4'b0000, 4'b0100};
        tbl[7] = '{4'd6,  4'b0000, 4'b0000};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata0", m_tdata[63:0], 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_s_tready", 64'(s_tready), 64'd1);
        @(negedge clk);

        // single-beat vector table
        for (int r = 0; r < 8; r++) begin
            m_tready = tbl[r].mr;
            s_tvalid = 1'b1;
            s_tlast  = 1'b1;
            s_tdata  = {tbl[r].dest, 60'hAB + 60'(r)};
            #1 chk($sformatf("tbl%0d_ready", r), 64'(s_tready), 64'd1);
            sample();
            s_tvalid = 1'b0;
            #1 chk($sformatf("tbl%0d_mvalid", r), 64'(m_tvalid), 64'(tbl[r].exp_mv));
            sample();
            m_tready = '1;
            sample();
            sample();
        end
        chk("tbl_drop_cnt", 64'(drop_cnt), 64'(drops));

        // 3-beat packet to port 1 with downstream stall
        m_tready = '1;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = {4'd1, 60'h100};
        #1 chk("stall_b0_ready", 64'(s_tready), 64'd1);
        sample();
        s_tdata  = {4'd1, 60'h101};
        m_tready = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("stall_ready_c%0d", c), 64'(s_tready), 64'd0);
            chk($sformatf("stall_hold_c%0d", c), m_tdata[127:64], {4'd1, 60'h100});
            chk($sformatf("stall_valid_c%0d", c), 64'(m_tvalid), 64'b0010);
            sample();
        end
        m_tready = '1;
        #1 chk("stall_release_ready", 64'(s_tready), 64'd1);
        sample();
        s_tdata = {4'd7, 60'h102};
        s_tlast = 1'b1;
        #1 chk("stall_tail_ready", 64'(s_tready), 64'd1);
        sample();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        sample();
        sample();

        // back-to-back: port 0 stalled blocks the following port 3 packet
        m_tready = 4'b1110;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = {4'd0, 60'h200};
        #1 chk("b2b_head_ready", 64'(s_tready), 64'd1);
        sample();
        s_tdata = {4'd0, 60'h201};
        s_tlast = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("b2b_block_c%0d", c), 64'(s_tready), 64'd0);
            chk($sformatf("b2b_p3_idle_c%0d", c), 64'(m_tvalid[3]), 64'd0);
            sample();
        end
        m_tready = '1;
        #1 chk("b2b_tail_ready", 64'(s_tready), 64'd1);
        sample();
        s_tdata = {4'd3, 60'h300};
        #1 chk("b2b_p3_before", 64'(m_tvalid[3]), 64'd0);
        chk("b2b_p3_ready", 64'(s_tready), 64'd1);
        sample();
        s_tvalid = 1'b0;
        #1 chk("b2b_p3_after", 64'(m_tvalid[3]), 64'd1);
        sample();
        sample();

        // illegal dest 4-beat packet is drained and counted
        d0 = drops;
        m_tready = '0;
        for (int b = 0; b < 4; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = {4'd5, 60'(b)};
            s_tlast  = (b == 3);
            #1 chk($sformatf("drop_ready_b%0d", b), 64'(s_tready), 64'd1);
            chk($sformatf("drop_mvalid_b%0d", b), 64'(m_tvalid), 64'd0);
            sample();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = '1;
        #1 chk("drop_cnt_inc", 64'(drop_cnt), 64'(d0 + 1));
        sample();

        // reset in the middle of a packet to port 1
        for (int b = 0; b < 2; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = {4'd1, 60'h400 + 60'(b)};
            sample();
        end
        s_tvalid = 1'b0;
        m_tready = 4'b1101;
        sample();
        #1 chk("mid_rst_before", 64'(m_tvalid), 64'b0010);
        rst_n = 1'b0;
        #1 chk("mid_rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_ready", 64'(s_tready), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < S; i++) q[i].delete();
        mid   = 1'b0;
        drops = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_tready = '1;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = {4'd3, 60'h500};
        #1 chk("post_rst_head_ready", 64'(s_tready), 64'd1);
        sample();
        s_tvalid = 1'b0;
        #1 chk("post_rst_route", 64'(m_tvalid), 64'b1000);
        sample();

`ifdef AXIS_SPLIT_BROADCAST_EN
        // broadcast waits for every slot, then lands on all ports
        d0 = drops;
        m_tready = 4'b1011;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = {4'd2, 60'h600};
        sample();
        s_tlast = 1'b0;
        s_tdata = {4'hF, 60'h601};
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("bc_stall_c%0d", c), 64'(s_tready), 64'd0);
            sample();
        end
        m_tready = '1;
        #1 chk("bc_head_ready", 64'(s_tready), 64'd1);
        sample();
        s_tdata = {4'hF, 60'h602};
        s_tlast = 1'b1;
        #1 chk("bc_head_all", 64'(m_tvalid), 64'b1111);
        chk("bc_tail_ready", 64'(s_tready), 64'd1);
        sample();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1 chk("bc_tail_all", 64'(m_tvalid), 64'b1111);
        sample();
        chk("bc_no_drop", 64'(drop_cnt), 64'(d0));
`endif

        // random packets, random gaps and random downstream backpressure
        for (int p = 0; p < 300; p++) begin
            len = $urandom_range(1, 4);
            d   = dsel[$urandom_range(0, 6)];
            for (int b = 0; b < len; b++) begin
                s_tdata = {(b == 0) ? d : 4'($urandom), 28'($urandom), 32'($urandom)};
                s_tlast = (b == len - 1);
                guard = 0;
                do begin
                    s_tvalid = ($urandom_range(0, 3) != 0);
                    m_tready = 4'($urandom) | 4'($urandom);
                    sample();
                    guard++;
                end while (!acc && guard < 200);
                if (!acc) begin
                    n_chk++;
                    $display("FAIL rand_accept_timeout pkt %0d beat %0d got no accept want accept", p, b);
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = '1;
        for (int c = 0; c < 4; c++) sample();
        for (int i = 0; i < S; i++) chk($sformatf("rand_drain_q%0d", i), 64'(q[i].size()), 64'd0);
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(drops));

        // saturation of the drop counter with back-to-back single-beat drops
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = {4'd5, 60'h700};
        for (int n = 0; n < 65537; n++) begin
            if (n == 1000) chk("sat_mid_count", 64'(drop_cnt), 64'(drops));
            sample();
        end
        s_tvalid = 1'b0;
        #1 chk("sat_drop_cnt", 64'(drop_cnt), 64'hFFFF);
        chk("sat_model", 64'(drop_cnt), 64'(drops));
        chk("sat_mvalid", 64'(m_tvalid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
